// File: rtl/shift_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_dispatcher_if
// Description : Request, shifter stb/ack and result channels of the shift dispatcher.
// Revision    : 1.0  initial release
// ============================================================================
interface shift_dispatcher_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic                  req_alu32;
    logic [DATA_WIDTH-1:0] req_dst;
    logic [DATA_WIDTH-1:0] req_src;
    logic                  sh_stb;
    logic                  sh_arith;
    logic                  sh_left;
    logic [DATA_WIDTH-1:0] sh_value;
    logic [DATA_WIDTH-1:0] sh_shift;
    logic [DATA_WIDTH-1:0] sh_out;
    logic                  sh_ack;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;

    // The dispatcher is the initiator of the shifter handshake.
    modport master (
        input  req_valid, req_op, req_alu32, req_dst, req_src, sh_out, sh_ack, res_ready,
        output req_ready, sh_stb, sh_arith, sh_left, sh_value, sh_shift,
               res_valid, res_data, res_err
    );

    modport slave (
        output req_valid, req_op, req_alu32, req_dst, req_src, sh_out, sh_ack, res_ready,
        input  req_ready, sh_stb, sh_arith, sh_left, sh_value, sh_shift,
               res_valid, res_data, res_err
    );
endinterface
`default_nettype wire

// File: rtl/shift_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : shift_dispatcher
// Description : Applies eBPF shift semantics and drives one stb/ack shifter transaction per op.
// Revision    : 1.0  initial release
// ============================================================================
module shift_dispatcher #(
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 16,
    parameter int TMO_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    shift_dispatcher_if.master bus
);
    localparam logic [TMO_W-1:0]      c_TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] c_MASK64    = DATA_WIDTH'(63);
    localparam logic [DATA_WIDTH-1:0] c_MASK32    = DATA_WIDTH'(31);
    localparam logic [1:0]            c_OP_LSH    = 2'b00;
    localparam logic [1:0]            c_OP_ARSH   = 2'b10;
    localparam logic [1:0]            c_OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_alu32;
    logic                  r_sh_stb;
    logic                  r_sh_arith;
    logic                  r_sh_left;
    logic [DATA_WIDTH-1:0] r_sh_value;
    logic [DATA_WIDTH-1:0] r_sh_shift;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_res_err;
    logic [TMO_W-1:0]      r_wdog;

    logic [DATA_WIDTH-1:0] w_dst_zext;
    logic [DATA_WIDTH-1:0] w_dst_sext;
    logic [DATA_WIDTH-1:0] w_ack_result;

    assign w_dst_zext   = {{(DATA_WIDTH-32){1'b0}}, bus.req_dst[31:0]};
    assign w_dst_sext   = {{(DATA_WIDTH-32){bus.req_dst[31]}}, bus.req_dst[31:0]};
    // ALU32 results are truncated and zero-extended regardless of shift direction.
    assign w_ack_result = r_alu32 ? {{(DATA_WIDTH-32){1'b0}}, bus.sh_out[31:0]} : bus.sh_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_alu32     <= 1'b0;
            r_sh_stb    <= 1'b0;
            r_sh_arith  <= 1'b0;
            r_sh_left   <= 1'b0;
            r_sh_value  <= '0;
            r_sh_shift  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_op == c_OP_ILLEGAL) begin
                            // Illegal ops never reach the shifter; its operand regs keep their values.
                            r_res_data  <= '0;
                            r_res_err   <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_alu32    <= bus.req_alu32;
                            r_sh_left  <= (bus.req_op == c_OP_LSH);
                            r_sh_arith <= (bus.req_op == c_OP_ARSH);
                            r_sh_shift <= bus.req_src & (bus.req_alu32 ? c_MASK32 : c_MASK64);
                            if (!bus.req_alu32) begin
                                r_sh_value <= bus.req_dst;
                            end else if (bus.req_op == c_OP_ARSH) begin
                                r_sh_value <= w_dst_sext;
                            end else begin
                                r_sh_value <= w_dst_zext;
                            end
                            r_sh_stb   <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_sh_stb <= 1'b0;
                    r_wdog   <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack arriving on the watchdog's final cycle still wins.
                    if (bus.sh_ack) begin
                        r_res_data  <= w_ack_result;
                        r_res_err   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wdog == c_TMO_LAST) begin
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + TMO_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.sh_stb    = r_sh_stb;
    assign bus.sh_arith  = r_sh_arith;
    assign bus.sh_left   = r_sh_left;
    assign bus.sh_value  = r_sh_value;
    assign bus.sh_shift  = r_sh_shift;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
endmodule
`default_nettype wire

// File: tb/tb_shift_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_dispatcher
// Description : Directed bench for shift_dispatcher with an eBPF-level model and shifter responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_dispatcher;
    localparam int DW  = 64;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_dispatcher_if #(.DATA_WIDTH(DW)) bus ();

    shift_dispatcher #(.DATA_WIDTH(DW), .TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- shifter responder ----------------
    int ack_delay = 2;
    bit mute      = 1'b0;
    bit poke      = 1'b0;
    int stb_count = 0;
    int r_cnt     = 0;

    function automatic logic [63:0] shifter(input logic [63:0] v, input logic [63:0] s,
                                            input logic left, input logic arith);
        int n;
        logic signed [63:0] sv;
        n  = int'(s[5:0]);
        sv = v;
        if (left)  return v << n;
        if (arith) return sv >>> n;
        return v >> n;
    endfunction

    initial begin
        bus.sh_ack = 1'b0;
        bus.sh_out = '0;
        forever begin
            @(posedge clk); #1;
            bus.sh_ack = 1'b0;
            if (poke) begin
                bus.sh_out = 64'hDEAD_BEEF_0BAD_F00D;
                bus.sh_ack = 1'b1;
                poke       = 1'b0;
            end
            if (r_cnt > 0) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    bus.sh_out = shifter(bus.sh_value, bus.sh_shift, bus.sh_left, bus.sh_arith);
                    bus.sh_ack = 1'b1;
                end
            end
            if (bus.sh_stb) begin
                stb_count++;
                if (!mute) r_cnt = ack_delay;
            end
        end
    end

    // ---------------- eBPF reference model ----------------
    typedef struct {
        int          acc;
        int          due;
        bit          legal;
        logic [63:0] data;
        logic        err;
        logic [63:0] val;
        logic [63:0] sft;
        logic        left;
        logic        arith;
    } exp_t;

    exp_t q[$];

    function automatic logic [63:0] ebpf(input logic [1:0] op, input logic a32,
                                         input logic [63:0] d, input logic [63:0] s);
        logic signed [31:0] x;
        logic signed [63:0] y;
        int n;
        if (a32) begin
            n = int'(s % 64'd32);
            x = d[31:0];
            if (op == 2'b00)      x = x << n;
            else if (op == 2'b01) x = x >> n;
            else                  x = x >>> n;
            return {32'h0, x};
        end
        n = int'(s % 64'd64);
        y = d;
        if (op == 2'b00)      y = y << n;
        else if (op == 2'b01) y = y >> n;
        else                  y = y >>> n;
        return y;
    endfunction

    function automatic exp_t model(input int acc);
        exp_t        e;
        logic [1:0]  op;
        logic        a32;
        logic [63:0] d;
        logic [63:0] s;
        op  = bus.req_op;
        a32 = bus.req_alu32;
        d   = bus.req_dst;
        s   = bus.req_src;
        e.acc   = acc;
        e.legal = (op != 2'b11);
        e.left  = (op == 2'b00);
        e.arith = (op == 2'b10);
        e.sft   = a32 ? (s % 64'd32) : (s % 64'd64);
        if (!a32)              e.val = d;
        else if (op == 2'b10)  e.val = {{32{d[31]}}, d[31:0]};
        else                   e.val = {32'h0, d[31:0]};
        if (!e.legal) begin
            e.due = acc + 1; e.data = '0; e.err = 1'b1;
        end else if (!mute && ack_delay <= TMO) begin
            e.due = acc + 2 + ack_delay; e.data = ebpf(op, a32, d, s); e.err = 1'b0;
        end else begin
            e.due = acc + 2 + TMO; e.data = '0; e.err = 1'b1;
        end
        return e;
    endfunction

    // ---------------- per-cycle compare ----------------
    bit rst_seen = 1'b0;

    always @(negedge clk) begin : p_cmp
        exp_t e;
        if (rst) begin
            q.delete();
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                chk("post_rst_sh_stb",    bus.sh_stb,    0);
                chk("post_rst_sh_value",  bus.sh_value,  0);
                chk("post_rst_sh_shift",  bus.sh_shift,  0);
                chk("post_rst_sh_flags",  {bus.sh_left, bus.sh_arith}, 0);
                chk("post_rst_res_valid", bus.res_valid, 0);
                chk("post_rst_res_data",  bus.res_data,  0);
                chk("post_rst_res_err",   bus.res_err,   0);
                rst_seen = 1'b0;
            end
            chk("req_ready", bus.req_ready, q.size() == 0);
            if (q.size() == 0) begin
                chk("idle_sh_stb",    bus.sh_stb,    0);
                chk("idle_res_valid", bus.res_valid, 0);
            end else begin
                e = q[0];
                chk("sh_stb", bus.sh_stb, e.legal && (cyc == e.acc + 1));
                if (e.legal && cyc > e.acc) begin
                    chk("sh_value", bus.sh_value, e.val);
                    chk("sh_shift", bus.sh_shift, e.sft);
                    chk("sh_left",  bus.sh_left,  e.left);
                    chk("sh_arith", bus.sh_arith, e.arith);
                end
                chk("res_valid", bus.res_valid, cyc >= e.due);
                if (bus.res_valid) begin
                    chk("res_data", bus.res_data, e.data);
                    chk("res_err",  bus.res_err,  e.err);
                    if (bus.res_ready) void'(q.pop_front());
                end
            end
            if (bus.req_valid && bus.req_ready) q.push_back(model(cyc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic a32, input logic [63:0] dst,
                         input logic [63:0] src, input int hold,
                         output logic [63:0] data, output logic err, output int lat);
        chk("pre_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_alu32 = a32;
        bus.req_dst   = dst;
        bus.req_src   = src;
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 40) begin
            tick();
            lat++;
        end
        data = bus.res_data;
        err  = bus.res_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_res_valid", bus.res_valid, 1);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic        e;
        int          l;
        int          s0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_alu32 = 1'b0;
        bus.req_dst   = '0;
        bus.req_src   = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_sh_stb",    bus.sh_stb,    0);
        chk("rst_sh_value",  bus.sh_value,  0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data",  bus.res_data,  0);
        chk("rst_req_ready", bus.req_ready, 1);
        rst = 1'b0;
        tick();

        do_op(2'b00, 1'b0, 64'h1, 64'h43, 0, d, e, l);
        chk("t1_data", d, 64'h8); chk("t1_err", e, 0); chk("t1_lat", l, 4);
        chk("t1_sh_shift", bus.sh_shift, 64'd3);

        do_op(2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 0, d, e, l);
        chk("t2_data", d, 64'h0000_0000_F800_0000);
        chk("t2_sh_value", bus.sh_value, 64'hFFFF_FFFF_8000_0000);

        do_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 0, d, e, l);
        chk("t3a_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd36, 0, d, e, l);
        chk("t3b_data", d, 64'h0000_0000_0FFF_FFFF);

        s0 = stb_count;
        do_op(2'b11, 1'b0, 64'h55, 64'd1, 0, d, e, l);
        chk("t4_lat", l, 1); chk("t4_err", e, 1); chk("t4_data", d, 0);
        chk("t4_no_stb", stb_count, s0);

        mute = 1'b1;
        do_op(2'b01, 1'b0, 64'hF0, 64'd4, 0, d, e, l);
        chk("t5_lat", l, 18); chk("t5_err", e, 1); chk("t5_data", d, 0);
        mute = 1'b0;
        poke = 1'b1;
        repeat (3) tick();
        chk("t5_late_ack_valid", bus.res_valid, 0);
        do_op(2'b00, 1'b0, 64'h3, 64'd1, 0, d, e, l);
        chk("t5_next_data", d, 64'h6); chk("t5_next_lat", l, 4);

        ack_delay = 16;
        do_op(2'b01, 1'b0, 64'h100, 64'd8, 0, d, e, l);
        chk("ack_wins_data", d, 64'h1); chk("ack_wins_err", e, 0); chk("ack_wins_lat", l, 18);
        ack_delay = 17;
        do_op(2'b01, 1'b0, 64'h100, 64'd8, 0, d, e, l);
        chk("tmo_err", e, 1); chk("tmo_lat", l, 18);
        ack_delay = 2;
        tick();

        do_op(2'b00, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'd33, 0, d, e, l);
        chk("lsh32_data", d, 64'h2);
        do_op(2'b01, 1'b0, 64'h1234, 64'd64, 0, d, e, l);
        chk("rsh64_mask0", d, 64'h1234);

        do_op(2'b00, 1'b0, 64'hA, 64'd2, 5, d, e, l);
        chk("t6_data", d, 64'h28); chk("t6_lat", l, 4);

        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_alu32 = 1'b0;
        bus.req_dst   = 64'hFF;
        bus.req_src   = 64'd4;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_wait_ready", bus.req_ready, 1);
        chk("rst_wait_stb",   bus.sh_stb,    0);
        chk("rst_wait_value", bus.sh_value,  0);
        chk("rst_wait_valid", bus.res_valid, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_wait_dropped", bus.res_valid, 0);
        do_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd4, 0, d, e, l);
        chk("recover_data", d, 64'hFFFF_FFFF_FFFF_FFF0); chk("recover_lat", l, 4);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
